// File: rtl/bwt_pkg.sv
// Shared types and width helpers for the BWT suffix-sort blocks
// (ranker, sorter, prefix-doubling controller).
package bwt_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int RANK_DENSE = 0;
  localparam int RANK_HEAD  = 1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rank_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bucket_store.sv
// Rank storage: register array with one write port and a registered read port.
// A read of the address written on the same edge returns the pre-write value.
module bucket_store #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int RANK_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [RANK_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [RANK_W-1:0] rd_data
);

  logic [RANK_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/bucket_ranker.sv
// Assigns bucket ranks to a sorted (key_hi, key_lo, idx) stream and reports
// the highest rank and whether every key group held a single tuple.
module bucket_ranker
  import bwt_pkg::*;
#(
  parameter  int STRING_LEN = 8,
  parameter  int KEY_W      = 8,
  parameter  int RANK_MODE  = RANK_DENSE,
  localparam int IDX_W      = idx_width(STRING_LEN),
  localparam int RANK_W     = rank_width(STRING_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [KEY_W-1:0]  in_key_hi,
  input  logic [KEY_W-1:0]  in_key_lo,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic              in_last,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [RANK_W-1:0] rd_data,
  output logic [RANK_W-1:0] max_bucket,
  output logic              all_unique,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [RANK_W-1:0] LEN = RANK_W'(STRING_LEN);

  state_t            state, state_nx;
  logic [RANK_W-1:0] cnt, rank, groups;
  logic [KEY_W-1:0]  prev_hi, prev_lo;
  logic              accept, is_new, idx_ok, pass_end;
  logic [RANK_W-1:0] pos, rank_nx, groups_nx;

  function automatic logic [RANK_W-1:0] sat_inc(input logic [RANK_W-1:0] v);
    return (v >= LEN) ? LEN : v + RANK_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // rank/groups start at 0, so the first tuple lands on 1 in both modes
  // without a dedicated first-tuple branch.
  always_comb begin
    in_ready  = (state == RUN);
    busy      = (state == RUN);
    done      = (state == DONE);
    accept    = in_valid && (state == RUN);
    pos       = cnt + RANK_W'(1);
    is_new    = (cnt == '0) || (in_key_hi != prev_hi) || (in_key_lo != prev_lo);
    idx_ok    = RANK_W'(in_idx) < LEN;
    groups_nx = is_new ? sat_inc(groups) : groups;
    rank_nx   = rank;
    if (is_new) rank_nx = (RANK_MODE == RANK_HEAD) ? pos : sat_inc(rank);
    pass_end  = accept && (in_last || (pos == LEN));
    state_nx  = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (pass_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      rank       <= '0;
      groups     <= '0;
      prev_hi    <= '0;
      prev_lo    <= '0;
      max_bucket <= '0;
      all_unique <= 1'b0;
      err        <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt        <= '0;
      rank       <= '0;
      groups     <= '0;
      prev_hi    <= '0;
      prev_lo    <= '0;
      max_bucket <= '0;
      all_unique <= 1'b0;
      err        <= 1'b0;
    end else if (accept) begin
      cnt        <= pos;
      rank       <= rank_nx;
      groups     <= groups_nx;
      prev_hi    <= in_key_hi;
      prev_lo    <= in_key_lo;
      max_bucket <= rank_nx;
      all_unique <= (groups_nx == LEN);
      if (!idx_ok || (in_last != (pos == LEN))) err <= 1'b1;
    end
  end

  bucket_store #(
    .DEPTH  (STRING_LEN),
    .IDX_W  (IDX_W),
    .RANK_W (RANK_W)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && idx_ok),
    .wr_addr (in_idx),
    .wr_data (rank_nx),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_bucket_ranker.sv
// Randomized bench: two rankers (dense and head mode) share one stream and are
// compared against a history-based rank model.
module tb_bucket_ranker;

  localparam int L = 6;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_last;
  logic [7:0] key_hi, key_lo;
  logic [2:0] in_idx, rd_addr;
  logic       in_ready0, in_ready1, au0, au1, busy0, busy1, done0, done1, err0, err1;
  logic [2:0] rd_data0, rd_data1, max0, max1;

  always #5 clk = ~clk;

  bucket_ranker #(.STRING_LEN(L), .KEY_W(8), .RANK_MODE(0)) u_dense (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
    .in_key_hi(key_hi), .in_key_lo(key_lo), .in_idx(in_idx), .in_last(in_last),
    .rd_addr(rd_addr), .rd_data(rd_data0), .max_bucket(max0), .all_unique(au0),
    .busy(busy0), .done(done0), .err(err0)
  );

  bucket_ranker #(.STRING_LEN(L), .KEY_W(8), .RANK_MODE(1)) u_head (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .in_key_hi(key_hi), .in_key_lo(key_lo), .in_idx(in_idx), .in_last(in_last),
    .rd_addr(rd_addr), .rd_data(rd_data1), .max_bucket(max1), .all_unique(au1),
    .busy(busy1), .done(done1), .err(err1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int bk0[L];
  int bk1[L];
  int hist[L];
  int n_acc;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Dense rank: number of distinct keys seen up to and including tuple p.
  function automatic int dense_at(input int p);
    int r = 1;
    for (int j = 1; j <= p; j++) if (hist[j] != hist[j-1]) r++;
    return r;
  endfunction

  // Head rank: 1-based position of the first tuple of p's key group.
  function automatic int head_at(input int p);
    int q = p;
    while (q > 0 && hist[q-1] == hist[p]) q--;
    return q + 1;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, int'(in_ready0) + int'(in_ready1), 0);
    check({tag, "_busy"},  int'(busy0) + int'(busy1), 0);
    check({tag, "_done"},  int'(done0) + int'(done1), 0);
    check({tag, "_err"},   int'(err0) + int'(err1), 0);
    check({tag, "_max0"},  int'(max0), 0);
    check({tag, "_max1"},  int'(max1), 0);
    check({tag, "_uniq"},  int'(au0) + int'(au1), 0);
    check({tag, "_rd0"},   int'(rd_data0), 0);
    check({tag, "_rd1"},   int'(rd_data1), 0);
  endtask

  task automatic readback();
    for (int a = 0; a < L; a++) begin
      rd_addr = 3'(a);
      tick();
      check("rd_dense", int'(rd_data0), bk0[a]);
      check("rd_head",  int'(rd_data1), bk1[a]);
    end
  endtask

  // kind: 0 random keys, 1 all distinct, 2 in_last on 3rd tuple,
  //       3 no in_last, 4 one out-of-range idx
  task automatic run_pass(input int kind, input bit hold_start, input bit gaps);
    int perm[L];
    int n, v, bp, idx, d, h, tmp, k, old0, old1;
    bit exp_err;
    n  = (kind == 2) ? 3 : L;
    bp = (kind == 4) ? int'($urandom_range(0, L-1)) : -1;
    for (int i = 0; i < L; i++) perm[i] = i;
    for (int i = L-1; i > 0; i--) begin
      k = int'($urandom_range(0, i));
      tmp = perm[i]; perm[i] = perm[k]; perm[k] = tmp;
    end

    in_valid = 1'b1; in_last = 1'b1; in_idx = 3'(perm[0]);
    key_hi = 8'($urandom); key_lo = 8'($urandom);
    tick();
    check("idle_ready", int'(in_ready0) + int'(in_ready1), 0);

    in_valid = 1'b0; start = 1'b1;
    tick();
    check("run_busy", int'(busy0) + int'(busy1), 2);
    check("run_err_clr", int'(err0) + int'(err1), 0);
    if (!hold_start) start = 1'b0;

    n_acc = 0; exp_err = 1'b0; d = 0; h = 0;
    v = int'($urandom_range(0, 2000));
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      if (i > 0 && (kind == 1 || $urandom_range(0, 1) == 1)) v += int'($urandom_range(1, 300));
      idx      = (i == bp) ? int'($urandom_range(L, 7)) : perm[i];
      in_valid = 1'b1;
      key_hi   = 8'(v >> 8);
      key_lo   = 8'(v & 255);
      in_idx   = 3'(idx);
      in_last  = (kind != 3) && (i == n-1);
      rd_addr  = (idx < L) ? 3'(idx) : 3'd0;
      old0     = bk0[int'(rd_addr)];
      old1     = bk1[int'(rd_addr)];
      check("run_ready", int'(in_ready0) + int'(in_ready1), 2);
      tick();
      hist[n_acc] = v;
      d = dense_at(n_acc);
      h = head_at(n_acc);
      n_acc++;
      if (idx < L) begin
        bk0[idx] = d;
        bk1[idx] = h;
      end else exp_err = 1'b1;
      if (in_last && n_acc != L) exp_err = 1'b1;
      if (!in_last && n_acc == L) exp_err = 1'b1;
      check("rd_old_dense", int'(rd_data0), old0);
      check("rd_old_head",  int'(rd_data1), old1);
    end

    check("done_pulse", int'(done0) + int'(done1), 2);
    check("done_busy", int'(busy0) + int'(busy1), 0);
    check("done_ready", int'(in_ready0) + int'(in_ready1), 0);
    check("max_dense", int'(max0), d);
    check("max_head", int'(max1), h);
    check("uniq_dense", int'(au0), int'(d == L));
    check("uniq_head", int'(au1), int'(d == L));
    check("err_dense", int'(err0), int'(exp_err));
    check("err_head", int'(err1), int'(exp_err));

    in_valid = 1'b1; in_last = 1'b1; in_idx = 3'(perm[0]);
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("done_one_cycle", int'(done0) + int'(done1), 0);
    check("held_max", int'(max0), d);
    check("held_err", int'(err1), int'(exp_err));
    tick();
    check("no_second_pass", int'(busy0) + int'(busy1), 0);
    readback();
  endtask

  task automatic mid_pass_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_last = 1'b0; in_idx = 3'(i);
      key_hi = 8'(i); key_lo = 8'($urandom);
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("midrst");
    for (int a = 0; a < L; a++) begin
      bk0[a] = 0;
      bk1[a] = 0;
    end
    readback();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    key_hi = '0; key_lo = '0; in_idx = '0; rd_addr = '0;
    for (int a = 0; a < L; a++) begin
      bk0[a] = 0;
      bk1[a] = 0;
    end
    repeat (2) tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();

    run_pass(0, 1'b0, 1'b0);
    run_pass(1, 1'b0, 1'b1);
    run_pass(2, 1'b0, 1'b0);
    run_pass(4, 1'b0, 1'b1);
    run_pass(3, 1'b0, 1'b0);
    run_pass(0, 1'b1, 1'b1);
    mid_pass_reset();
    run_pass(1, 1'b0, 1'b0);
    for (int t = 0; t < 12; t++)
      run_pass(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
